addsub_seq: RTL and testbench

- Parametrised multi-cycle add/subtract unit. It is the successor to the combinational 16-bit adder with carry in and carry out.
- Processes operands CHUNK bits per clock, LSB slice first, propagating carry between cycles. This trades latency for a narrow adder.
- Valid/ready handshake on both input and output, so it sits between a producer and a consumer in the arithmetic datapath.
- Adds a subtract mode and status flags (carry/borrow, signed overflow, zero).

---
 rtl/arith_pkg.sv | 24 ++
 rtl/add_slice.sv | 26 ++
 rtl/addsub_seq.sv | 164 ++++++++++++++++
 tb/tb_addsub_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential add/subtract datapath:
// FSM states, operation encoding and step/counter sizing helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of slices needed to cover the full operand width.
    function automatic int calc_nstep(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Step counter width; a single-step configuration still keeps one bit.
    function automatic int calc_cnt_w(input int nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-bit adder slice. Besides sum and carry-out it reports
// the carry into its MSB, which the top uses for signed overflow on the
// final slice.
module add_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    // One extra bit captures the carry out; the MSB carry-in is recovered
    // from the MSB sum bit, which also works when CHUNK is 1.
    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum   = full[CHUNK-1:0];
        cout  = full[CHUNK];
        c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit. Operands are consumed CHUNK bits per clock,
// LSB slice first, with the carry held in a register between cycles.
// Subtraction is performed as e1 + ~e2 + ~r0, so one narrow adder serves
// both operations. Valid/ready handshakes on both sides.
module addsub_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic             r0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             r1,
    output logic             ovf,
    output logic             zero
);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("addsub_seq: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    localparam int NSTEP = calc_nstep(WIDTH, CHUNK);
    localparam int CNT_W = calc_cnt_w(NSTEP);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             op_q, op_d;
    logic             r1_q, r1_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout, slice_cmsb;

    assign slice_a = a_q[cnt_q*CHUNK +: CHUNK];
    assign slice_b = b_q[cnt_q*CHUNK +: CHUNK];

    add_slice #(.CHUNK(CHUNK)) u_add_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Next-state logic: operand capture, per-slice accumulation, flag update.
    always_comb begin
        // NOTE: every _d starts from its current value so no branch can infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        op_d        = op_q;
        r1_d        = r1_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = e1;
                    b_d        = (op == OP_SUB) ? ~e2 : e2;
                    carry_d    = (op == OP_SUB) ? ~r0 : r0;
                    op_d       = op;
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                    in_ready_d = 1'b0;
                end
            end
            ST_BUSY: begin
                acc_d[cnt_q*CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                if (cnt_q == LAST_STEP) begin
                    // Final slice: publish result and flags together.
                    s_d         = acc_d;
                    r1_d        = (op_q == OP_SUB) ? ~slice_cout : slice_cout;
                    ovf_d       = slice_cmsb ^ slice_cout;
                    zero_d      = (acc_d == '0);
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= OP_ADD;
            r1_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            r1_q        <= r1_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign r1        = r1_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed cases and random traffic on a
// 16/4 instance, plus random sweeps on 16/16, 16/1 and 32/8 instances, all
// compared against a plain-arithmetic reference model.
module tb_addsub_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sweep_go = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: integer arithmetic straight from the add/sub definitions.
    function automatic void ref_op(input int w, input logic o,
                                   input longint a, input longint b, input logic c,
                                   output longint xs, output logic xr1,
                                   output logic xovf, output logic xz);
        longint m, half, cc, d, sa, sb, res;
        m    = longint'(1) << w;
        half = m / 2;
        cc   = c ? 1 : 0;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (o == 1'b0) begin
            d   = a + b + cc;
            xr1 = (d >= m);
            xs  = d % m;
            res = sa + sb + cc;
        end else begin
            d   = a - b - cc;
            xr1 = (d < 0);
            xs  = (d < 0) ? d + m : d;
            res = sa - sb - cc;
        end
        xovf = (res >= half) || (res < -half);
        xz   = (xs == 0);
    endfunction

    // ---------------- primary 16/4 instance ----------------
    logic        iv, ir, op_i, r0_i, ov, ordy, r1_o, ovf_o, zero_o;
    logic [15:0] e1_i, e2_i, s_o;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .op        (op_i),
        .e1        (e1_i),
        .e2        (e2_i),
        .r0        (r0_i),
        .out_valid (ov),
        .out_ready (ordy),
        .s         (s_o),
        .r1        (r1_o),
        .ovf       (ovf_o),
        .zero      (zero_o)
    );

    // One operation on the 16/4 instance, starting and ending on a negedge.
    task automatic op16(input string tag, input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input int hold, input logic [15:0] xs,
                        input logic xr1, input logic xovf, input logic xz);
        int cyc;
        check({tag, ".in_ready"}, 64'(ir), 1);
        iv = 1'b1; op_i = o; e1_i = a; e2_i = b; r0_i = c; ordy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0; e1_i = 16'($urandom); e2_i = 16'($urandom); r0_i = 1'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ov && cyc < 100);
        check({tag, ".latency"}, 64'(cyc), 4);
        for (int i = 0; i < hold; i++) begin
            check({tag, ".hold_ov"}, 64'(ov), 1);
            check({tag, ".hold_ir"}, 64'(ir), 0);
            check({tag, ".hold_s"}, 64'(s_o), 64'(xs));
            iv = 1'b1; op_i = 1'($urandom); e1_i = 16'($urandom); e2_i = 16'($urandom);
            @(negedge clk);
        end
        iv = 1'b0;
        check({tag, ".s"}, 64'(s_o), 64'(xs));
        check({tag, ".r1"}, 64'(r1_o), 64'(xr1));
        check({tag, ".ovf"}, 64'(ovf_o), 64'(xovf));
        check({tag, ".zero"}, 64'(zero_o), 64'(xz));
        ordy = 1'b1;
        @(negedge clk);
        check({tag, ".post_ov"}, 64'(ov), 0);
        check({tag, ".post_ir"}, 64'(ir), 1);
    endtask

    // ---------------- parameter sweep instances ----------------
    localparam int SW [3] = '{16, 16, 32};
    localparam int SC [3] = '{16, 1, 8};

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = SW[g];
        localparam int C = SC[g];
        localparam int N = W / C;

        logic         iv, ir, o, r0, ov, ordy, r1, ovf, zero;
        logic [W-1:0] e1, e2, s;
        logic         done_flag = 1'b0;

        addsub_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .op        (o),
            .e1        (e1),
            .e2        (e2),
            .r0        (r0),
            .out_valid (ov),
            .out_ready (ordy),
            .s         (s),
            .r1        (r1),
            .ovf       (ovf),
            .zero      (zero)
        );

        function automatic logic [W-1:0] pick_operand();
            logic [W-1:0] v;
            case ($urandom_range(0, 7))
                0:       v = '1;
                1:       v = '0;
                2:       v = {1'b1, {(W-1){1'b0}}};
                default: v = W'($urandom);
            endcase
            return v;
        endfunction

        task automatic run_op(input int hold);
            logic         op_r, c_r, xr1, xovf, xz;
            logic [W-1:0] a_r, b_r;
            longint       xs;
            int           cyc;
            op_r = 1'($urandom); c_r = 1'($urandom);
            a_r = pick_operand(); b_r = pick_operand();
            ref_op(W, op_r, longint'(64'(a_r)), longint'(64'(b_r)), c_r, xs, xr1, xovf, xz);
            check("sweep.in_ready", 64'(ir), 1);
            iv = 1'b1; o = op_r; e1 = a_r; e2 = b_r; r0 = c_r; ordy = 1'b0;
            @(posedge clk);
            @(negedge clk);
            iv = 1'b0; e1 = W'($urandom); e2 = W'($urandom);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ov && cyc < 100);
            check("sweep.latency", 64'(cyc), 64'(N));
            for (int i = 0; i < hold; i++) begin
                check("sweep.hold_s", 64'(s), 64'(xs));
                @(negedge clk);
            end
            check("sweep.s", 64'(s), 64'(xs));
            check("sweep.r1", 64'(r1), 64'(xr1));
            check("sweep.ovf", 64'(ovf), 64'(xovf));
            check("sweep.zero", 64'(zero), 64'(xz));
            ordy = 1'b1;
            @(negedge clk);
            check("sweep.post_ov", 64'(ov), 0);
        endtask

        initial begin
            iv = 1'b0; o = 1'b0; r0 = 1'b0; ordy = 1'b0; e1 = '0; e2 = '0;
            wait (sweep_go);
            @(negedge clk);
            for (int i = 0; i < 1000; i++) run_op($urandom_range(0, 3));
            done_flag = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ra, rb;
        logic        ro, rc, xr1, xovf, xz;
        longint      xs;
        int          waited;

        iv = 1'b0; op_i = 1'b0; r0_i = 1'b0; ordy = 1'b0; e1_i = '0; e2_i = '0;
        #2 rst_n = 1'b0;
        #5;
        check("rst.in_ready", 64'(ir), 1);
        check("rst.out_valid", 64'(ov), 0);
        check("rst.s", 64'(s_o), 0);
        check("rst.flags", 64'({r1_o, ovf_o, zero_o}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready_first", 64'(ir), 1);

        op16("add_wrap",  1'b0, 'hFFFF, 'h0001, 1'b0, 0, 'h0000, 1'b1, 1'b0, 1'b1);
        op16("sub_neg",   1'b1, 'h0005, 'h0007, 1'b0, 0, 'hFFFE, 1'b1, 1'b0, 1'b0);
        op16("sub_bp",    1'b1, 'h0009, 'h0003, 1'b1, 5, 'h0005, 1'b0, 1'b0, 1'b0);
        op16("add_ovf",   1'b0, 'h7FFF, 'h0001, 1'b0, 0, 'h8000, 1'b0, 1'b1, 1'b0);
        op16("sub_ovf",   1'b1, 'h8000, 'h0001, 1'b0, 0, 'h7FFF, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of BUSY (step counter at 2).
        iv = 1'b1; op_i = 1'b0; e1_i = 'h1234; e2_i = 'h1111; r0_i = 1'b0; ordy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.in_ready", 64'(ir), 1);
        check("midrst.out_valid", 64'(ov), 0);
        check("midrst.s", 64'(s_o), 0);
        check("midrst.flags", 64'({r1_o, ovf_o, zero_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.in_ready_after", 64'(ir), 1);
        op16("after_rst", 1'b0, 'h1234, 'h1111, 1'b0, 0, 'h2345, 1'b0, 1'b0, 1'b0);

        sweep_go = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ro = 1'($urandom); rc = 1'($urandom);
            ra = (i % 9 == 0) ? 16'hFFFF : 16'($urandom);
            rb = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
            ref_op(16, ro, longint'(64'(ra)), longint'(64'(rb)), rc, xs, xr1, xovf, xz);
            op16("rand16_4", ro, ra, rb, rc, $urandom_range(0, 3), 16'(xs), xr1, xovf, xz);
        end

        waited = 0;
        while (!(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag)
               && waited < 60000) begin
            @(negedge clk);
            waited++;
        end
        check("sweep_done",
              64'({g_sweep[0].done_flag, g_sweep[1].done_flag, g_sweep[2].done_flag}), 'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
